// File: rtl/apb_req_arbiter_pkg.sv
// Shared state type and default widths for the APB request arbiter.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_SEL_W  = 2;
    localparam int DEF_WAIT_W = 8;

endpackage

// File: rtl/apb_req_arbiter_if.sv
// Command/response bus between the arbiter (master modport) and the APB master engine (slave modport).
interface apb_req_arbiter_if
    import apb_arb_pkg::*;
#(
    parameter int SEL_W  = DEF_SEL_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int WAIT_W = DEF_WAIT_W
);
    logic              start;
    logic              write;
    logic [SEL_W-1:0]  sel;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [WAIT_W-1:0] wait_cycles;
    logic [DATA_W-1:0] rdata;
    logic              stable;

    modport master (
        output start, write, sel, addr, wdata, wait_cycles,
        input  rdata, stable
    );

    modport slave (
        input  start, write, sel, addr, wdata, wait_cycles,
        output rdata, stable
    );
endinterface

// File: rtl/apb_req_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester with req high, scanning from rr_ptr upward with wrap.
module rr_picker
    import apb_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] pick,
    output logic             valid
);
    logic [PTR_W-1:0] idx;

    always_comb begin
        pick  = '0;
        valid = 1'b0;
        idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = PTR_W'((int'(rr_ptr) + i) % N_REQ);
            if (!valid && req[idx]) begin
                pick[idx] = 1'b1;
                valid     = 1'b1;
            end
        end
    end
endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB command port among N_REQ requesters, one transfer in flight.
// Define APB_ARB_TIMEOUT_EN to abort a transfer (err with done) after TIMEOUT cycles in WAIT.
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int SEL_W   = DEF_SEL_W,
    parameter int WAIT_W  = DEF_WAIT_W,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          req_write,
    input  logic [N_REQ*SEL_W-1:0]    req_sel,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_wdata,
    input  logic [N_REQ*WAIT_W-1:0]   req_wait,
    output logic [N_REQ-1:0]          grant,
    output logic [N_REQ-1:0]          done,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      err,
    apb_req_arbiter_if.master         bus
);
    localparam int PTR_W = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 4 || TIMEOUT < 1) begin : g_bad_param
        $error("apb_req_arbiter: N_REQ must be 2..4 and TIMEOUT must be positive");
    end

    arb_state_t        state_q;
    logic [PTR_W-1:0]  rr_ptr_q;
    logic [PTR_W-1:0]  owner_q;
    logic [N_REQ-1:0]  grant_q;
    logic [N_REQ-1:0]  done_q;
    logic              start_q;
    logic              write_q;
    logic [SEL_W-1:0]  sel_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [WAIT_W-1:0] wait_q;
    logic [DATA_W-1:0] rsp_rdata_q;

    logic [N_REQ-1:0]  pick;
    logic              pick_vld;
    logic [PTR_W-1:0]  pick_idx;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]  cnt_q;
    logic              err_q;
`endif

    rr_picker #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .pick   (pick),
        .valid  (pick_vld)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick[i]) pick_idx = PTR_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            grant_q     <= '0;
            done_q      <= '0;
            start_q     <= 1'b0;
            write_q     <= 1'b0;
            sel_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wait_q      <= '0;
            rsp_rdata_q <= '0;
`ifdef APB_ARB_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            // start/done/err are single-cycle pulses unless a state below re-asserts them
            start_q <= 1'b0;
            done_q  <= '0;
`ifdef APB_ARB_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        grant_q  <= pick;
                        owner_q  <= pick_idx;
                        write_q  <= req_write[pick_idx];
                        sel_q    <= req_sel[pick_idx*SEL_W +: SEL_W];
                        addr_q   <= req_addr[pick_idx*ADDR_W +: ADDR_W];
                        wdata_q  <= req_wdata[pick_idx*DATA_W +: DATA_W];
                        wait_q   <= req_wait[pick_idx*WAIT_W +: WAIT_W];
                        start_q  <= 1'b1;
                        state_q  <= ISSUE;
                    end
                end
                ISSUE: begin
`ifdef APB_ARB_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (bus.stable) begin
                        rsp_rdata_q <= bus.rdata;
                        done_q      <= grant_q;
                        state_q     <= DONE;
                    end
`ifdef APB_ARB_TIMEOUT_EN
                    // cnt_q counts completed WAIT cycles; this is the TIMEOUT-th one
                    else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        rsp_rdata_q <= '0;
                        done_q      <= grant_q;
                        err_q       <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                DONE: begin
                    grant_q  <= '0;
                    rr_ptr_q <= (owner_q == PTR_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant           = grant_q;
    assign done            = done_q;
    assign rsp_rdata       = rsp_rdata_q;
    assign bus.start       = start_q;
    assign bus.write       = write_q;
    assign bus.sel         = sel_q;
    assign bus.addr        = addr_q;
    assign bus.wdata       = wdata_q;
    assign bus.wait_cycles = wait_q;

`ifdef APB_ARB_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench for apb_req_arbiter: directed scenarios then randomized traffic against a round-robin model.
module tb_apb_req_arbiter;
    localparam int N  = 2;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int SW = 2;
    localparam int WW = 8;
`ifdef APB_ARB_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 64;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic [N-1:0]    req;
    logic [N-1:0]    req_write;
    logic [N*SW-1:0] req_sel;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N*WW-1:0] req_wait;
    logic [N-1:0]    grant;
    logic [N-1:0]    done;
    logic [DW-1:0]   rsp_rdata;
    logic            err;

    logic [AW-1:0] a_addr  [N];
    logic [DW-1:0] a_wdata [N];
    logic [SW-1:0] a_sel   [N];
    logic [WW-1:0] a_wait  [N];

    always_comb begin
        req_sel   = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_wait  = '0;
        for (int i = 0; i < N; i++) begin
            req_sel[i*SW +: SW]   = a_sel[i];
            req_addr[i*AW +: AW]  = a_addr[i];
            req_wdata[i*DW +: DW] = a_wdata[i];
            req_wait[i*WW +: WW]  = a_wait[i];
        end
    end

    apb_req_arbiter_if #(.SEL_W(SW), .ADDR_W(AW), .DATA_W(DW), .WAIT_W(WW)) bus ();

    apb_req_arbiter #(
        .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .SEL_W(SW), .WAIT_W(WW), .TIMEOUT(TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_write (req_write),
        .req_sel   (req_sel),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wait  (req_wait),
        .grant     (grant),
        .done      (done),
        .rsp_rdata (rsp_rdata),
        .err       (err),
        .bus       (bus)
    );

    int nchecks = 0;
    int nerr    = 0;
    int rr      = 0;   // model: requester that has first claim at the next arbitration

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic int model_pick(input logic [N-1:0] pend);
        for (int k = 0; k < N; k++) begin
            int idx = (rr + k) % N;
            if (pend[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic raise_req(input int k);
        a_addr[k]    = AW'($urandom);
        a_wdata[k]   = DW'($urandom);
        a_sel[k]     = SW'($urandom);
        a_wait[k]    = WW'($urandom);
        req_write[k] = 1'($urandom);
        req[k]       = 1'b1;
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_grant"}, grant, 0);
        check({pfx, "_done"}, done, 0);
        check({pfx, "_err"}, err, 0);
        check({pfx, "_start"}, bus.start, 0);
        check({pfx, "_write"}, bus.write, 0);
        check({pfx, "_sel"}, bus.sel, 0);
        check({pfx, "_addr"}, bus.addr, 0);
        check({pfx, "_wdata"}, bus.wdata, 0);
        check({pfx, "_wait"}, bus.wait_cycles, 0);
        check({pfx, "_rsp"}, rsp_rdata, 0);
    endtask

    task automatic wait_start(output bit seen);
        seen = 1'b0;
        for (int t = 0; t < 12; t++) begin
            if (bus.start === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // One complete transfer as seen from the APB side; stable is raised on the dly-th WAIT cycle.
    task automatic serve(input int dly, input logic [DW-1:0] rd, input bit spur, input bit mutate,
                         input logic [N-1:0] raise, input bit drop, input bit stab_done,
                         output int own);
        bit            seen;
        logic [AW-1:0] e_addr;
        logic          e_wr;
        own = model_pick(req);
        check("serve_pending", 32'(own >= 0), 1);
        if (own < 0) return;
        e_addr = a_addr[own];
        e_wr   = req_write[own];
        wait_start(seen);
        check("start_seen", 32'(seen), 1);
        if (!seen) return;
        check("grant_at_start", grant, 32'(1) << own);
        check("cmd_addr", bus.addr, e_addr);
        check("cmd_wdata", bus.wdata, a_wdata[own]);
        check("cmd_sel", bus.sel, a_sel[own]);
        check("cmd_write", bus.write, e_wr);
        check("cmd_wait", bus.wait_cycles, a_wait[own]);
        if (spur) bus.stable = 1'b1;
        for (int i = 1; i <= dly; i++) begin
            tick();
            bus.stable = (i == dly);
            bus.rdata  = (i == dly) ? rd : DW'($urandom);
            if (i == 1) begin
                if (mutate) begin
                    a_addr[own]    = a_addr[own] + 8'h10;
                    a_wdata[own]   = ~a_wdata[own];
                    req_write[own] = ~req_write[own];
                end
                for (int k = 0; k < N; k++)
                    if (raise[k] && !req[k] && k != own) raise_req(k);
                if (drop) req[own] = 1'b0;
            end
            check("start_once", bus.start, 0);
            check("no_early_done", done, 0);
            check("addr_hold", bus.addr, e_addr);
            check("grant_hold", grant, 32'(1) << own);
        end
        tick();
        bus.stable = stab_done;
        check("done_owner", done, 32'(1) << own);
        check("done_grant", grant, 32'(1) << own);
        check("done_err", err, 0);
        check("done_nostart", bus.start, 0);
        if (!e_wr) check("rsp_rdata", rsp_rdata, rd);
        req[own] = 1'b0;
        rr = (own + 1) % N;
        tick();
        bus.stable = 1'b0;
        check("idle_done_clear", done, 0);
        check("idle_grant_clear", grant, 0);
    endtask

    initial begin
        int  own;
        bit  seen;
        reset      = 1'b0;
        req        = '0;
        req_write  = '0;
        bus.stable = 1'b0;
        bus.rdata  = '0;
        for (int i = 0; i < N; i++) begin
            a_addr[i] = '0; a_wdata[i] = '0; a_sel[i] = '0; a_wait[i] = '0;
        end
        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b1;
        tick();

        // Simultaneous requests, re-asserted right after each done: strict alternation.
        a_addr[0] = 8'h40; a_wdata[0] = 8'h11; a_sel[0] = 2'd1; a_wait[0] = 8'd3; req_write[0] = 1'b1;
        a_addr[1] = 8'h50; a_wdata[1] = 8'h22; a_sel[1] = 2'd2; a_wait[1] = 8'd4; req_write[1] = 1'b0;
        req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            serve(2, 8'h90 + 8'(k), 0, 0, '0, 0, 0, own);
            req[own] = 1'b1;
        end
        req = '0;
        tick();

        // Single read.
        a_sel[0] = 2'b01; a_addr[0] = 8'h10; a_wait[0] = 8'd2; req_write[0] = 1'b0; req[0] = 1'b1;
        serve(3, 8'hA5, 0, 0, '0, 0, 0, own);
        check("single_rsp_hold", rsp_rdata, 8'hA5);

        // Command stability: requester 1 moves its address while the transfer is in WAIT.
        a_addr[1] = 8'h20; req_write[1] = 1'b0; req[1] = 1'b1;
        serve(4, 8'h3C, 0, 1, '0, 0, 0, own);
        check("stab_new_addr", a_addr[1], 8'h30);

        // Reset mid-transfer with rr pointing at requester 1.
        raise_req(0);
        serve(2, 8'h01, 0, 0, '0, 0, 0, own);
        raise_req(1);
        wait_start(seen);
        check("rst_mid_start", 32'(seen), 1);
        tick();
        reset = 1'b0;
        req   = '0;
        tick();
        check_all_zero("rst_mid");
        reset = 1'b1;
        rr    = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_mid_no_done", done, 0);
            check("rst_mid_idle_grant", grant, 0);
        end
        raise_req(0);
        raise_req(1);
        serve(2, 8'h02, 0, 0, '0, 0, 0, own);
        check("rst_rr_zero_owner", grant, 0);
        serve(2, 8'h03, 0, 0, '0, 0, 0, own);
        raise_req(1);
        serve(1, 8'h04, 0, 0, '0, 0, 1, own);

        // Spurious stable in IDLE, then during ISSUE.
        bus.stable = 1'b1;
        tick();
        tick();
        check("spur_idle_done", done, 0);
        check("spur_idle_grant", grant, 0);
        check("spur_idle_start", bus.start, 0);
        bus.stable = 1'b0;
        raise_req(0);
        serve(2, 8'h5A, 1, 0, '0, 0, 0, own);

`ifdef APB_ARB_TIMEOUT_EN
        raise_req(0);
        wait_start(seen);
        check("to_start", 32'(seen), 1);
        for (int i = 1; i <= TO; i++) begin
            tick();
            check("to_no_early_done", done, 0);
            check("to_no_early_err", err, 0);
        end
        tick();
        check("to_done", done, 1);
        check("to_err", err, 1);
        check("to_rdata", rsp_rdata, 0);
        req[0] = 1'b0;
        rr = 1;
        tick();
        check("to_err_clear", err, 0);
        check("to_grant_clear", grant, 0);
        raise_req(0);
        serve(TO, 8'h77, 0, 0, '0, 0, 0, own);
`else
        raise_req(1);
        serve(70, 8'h66, 0, 0, '0, 0, 0, own);
`endif

        // Randomized traffic against the round-robin model.
        for (int n = 0; n < 30; n++) begin
            if (req == '0) raise_req(int'($urandom_range(0, N - 1)));
            serve(int'($urandom_range(1, 6)), DW'($urandom), 1'($urandom), 1'($urandom),
                  N'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom), own);
            for (int k = 0; k < N; k++)
                if (!req[k] && $urandom_range(0, 1) == 1) raise_req(k);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end
endmodule

// File: doc/apb_req_arbiter.md
Name: apb_req_arbiter

Overview:
- Shares the single processor-side command port of the APB master between N_REQ independent requesters, such as the CPU model and a DMA/test sequencer.
- Sits between the requesters and the master side of the processor bus. It drives start, write, sel, addr, wdata and wait_cycles, and consumes rdata and stable.
- Round-robin arbitration, one outstanding transfer at a time, registered command outputs, per-requester done/rdata return.

Parameters:
- N_REQ, 2, number of requesters (2..4)
- ADDR_W, 8, address width
- DATA_W, 8, write/read data width
- SEL_W, 2, slave-select width
- WAIT_W, 8, wait_cycles width
- TIMEOUT, 64, cycles allowed in WAIT before abort (used only with the optional feature)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- req  in  N_REQ  request per requester; held high until its done
- req_write  in  N_REQ  1=write, 0=read, per requester
- req_sel  in  N_REQ*SEL_W  slave select, flattened (requester i at [i*SEL_W +: SEL_W])
- req_addr  in  N_REQ*ADDR_W  address, flattened
- req_wdata  in  N_REQ*DATA_W  write data, flattened
- req_wait  in  N_REQ*WAIT_W  wait_cycles, flattened
- grant  out  N_REQ  one-hot; current owner, high from ISSUE through DONE
- done  out  N_REQ  one-hot, 1-cycle pulse; transfer complete
- rsp_rdata  out  DATA_W  read data; valid while done is high, held until next capture
- err  out  1  1-cycle pulse with done on abort (optional feature only, else tied 0)
- start  out  1  1-cycle pulse to APB master
- write  out  1  registered command to master
- sel  out  SEL_W  registered command to master
- addr  out  ADDR_W  registered command to master
- wdata  out  DATA_W  registered command to master
- wait_cycles  out  WAIT_W  registered command to master
- rdata  in  DATA_W  read data from master
- stable  in  1  master transfer complete

Behaviour:
- Reset (reset==0 at posedge clk) takes priority over everything:
  - state=IDLE, rr_ptr=0
  - grant, done, err, start, write, sel, addr, wdata, wait_cycles, rsp_rdata all 0
  - Reset mid-transfer abandons the transfer with no done; the requester must re-request.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any req is high, pick the first requester with req high, searching rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - Latch its write/sel/addr/wdata/wait_cycles into the output registers, set grant, go to ISSUE.
  - With no req, stay in IDLE; outputs hold their last values and start=0.
- ISSUE:
  - start=1 for exactly this cycle; next state WAIT.
  - stable is ignored in ISSUE.
- WAIT:
  - Hold all command outputs stable.
  - On stable==1: capture rdata into rsp_rdata (writes also capture; value is don't-care) and go to DONE.
- DONE:
  - done[owner]=1 for one cycle.
  - rr_ptr = owner+1 (wraps N_REQ-1 -> 0).
  - grant cleared on exit; next state IDLE.
- Latency:
  - req sampled at edge k -> start high in cycle k+1.
  - stable sampled at edge m -> done high in cycle m+1.
  - Minimum 4 cycles per transfer; no back-to-back start (at least 3 cycles between starts).
- Simultaneous requests: exactly one grant; the others wait without loss.
- Fairness: a requester that keeps req high is served at most once before every other pending requester.
- req dropped while granted: the transfer still completes and done still pulses; the arbiter never cancels an issued transfer.
- req re-asserted in the cycle after done: eligible normally, subject to the rotated rr_ptr.
- stable high while in IDLE or DONE: ignored.

Optional Feature:
- Macro: APB_ARB_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT+1) clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT with stable still low, go to DONE with err=1 alongside done[owner], and rsp_rdata=0.
  - stable in the same cycle the count reaches TIMEOUT wins: normal completion, err=0.
- Not defined: no counter; WAIT is unbounded; err is tied 0.

Decomposition:
- Package apb_arb_pkg:
  - state enum arb_state_t {IDLE, ISSUE, WAIT, DONE}
  - default width localparams (ADDR_W/DATA_W/SEL_W/WAIT_W = 8/8/2/8)
- Sub-module rr_picker: combinational round-robin selection. Inputs req, rr_ptr; outputs one-hot pick and a valid flag. Instantiated once.

Test Plan:
- Single read:
  - Stimulus: req[0]=1, sel=2'b01, addr=8'h10, wait=8'd2; master asserts stable 3 cycles after start with rdata=8'hA5.
  - Response: start pulses exactly once; done[0] pulses one cycle after stable; rsp_rdata=8'hA5; grant[0] drops after DONE.
- Simultaneous requests:
  - Stimulus: req=2'b11 held continuously, stable returned 2 cycles after each start.
  - Response: grant order 0,1,0,1; each done pulse matches the owner; addr/wdata match the owner's inputs on every start.
- Command stability:
  - Stimulus: requester 1 changes req_addr (8'h20 -> 8'h30) while in WAIT.
  - Response: addr output stays 8'h20 until DONE.
- Reset mid-transfer:
  - Stimulus: drive reset=0 for 1 cycle during WAIT.
  - Response: next cycle all outputs 0, state IDLE, no done pulse, rr_ptr=0; a following req[1] alone is granted normally.
- Spurious stable:
  - Stimulus: pulse stable in IDLE, then during the ISSUE cycle.
  - Response: no done and no state change; the transfer completes only on a stable seen in WAIT.
- Timeout (APB_ARB_TIMEOUT_EN, TIMEOUT=8):
  - Stimulus: stable never asserted.
  - Response: done[0] and err pulse together in the cycle after the 8th WAIT cycle; rsp_rdata=0.
  - Repeat with stable on the 8th WAIT cycle: err=0.
